// File: rtl/uart_servo_frame_tx.sv
// Bus-servo move frame builder feeding a single-byte UART transmitter.
// Optional watchdog: define TX_TIMEOUT_EN to abort a stalled byte with frame_err.
module uart_servo_frame_tx #(
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        frame_start,
  input  logic [7:0]  servo_id,
  input  logic [7:0]  cmd,
  input  logic [15:0] pos,
  input  logic [15:0] move_time,
  input  logic        tx_done,
  output logic [7:0]  data_byte,
  output logic        send_en,
  output logic        busy,
  output logic        frame_done,
  output logic        frame_err
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_GAP,
    S_DONE
  } state_t;

  state_t        state_q;
  logic [3:0]    idx_q;
  logic [GW-1:0] gap_q;
  logic [7:0]    id_q;
  logic [7:0]    cmd_q;
  logic [15:0]   pos_q;
  logic [15:0]   time_q;
  logic [7:0]    data_q;
  logic          send_q;
  logic          busy_q;
  logic          done_q;

`ifdef TX_TIMEOUT_EN
  localparam int WDW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [WDW-1:0] wd_q;
  logic           err_q;
`endif

  // Checksum covers bytes 2..8 (ID, LEN, cmd, pos, time)
  logic [11:0] sum;
  logic [7:0]  chk;
  logic [7:0]  frame_byte;

  assign sum = {4'h0, id_q} + 12'h007 + {4'h0, cmd_q}
             + {4'h0, pos_q[7:0]} + {4'h0, pos_q[15:8]}
             + {4'h0, time_q[7:0]} + {4'h0, time_q[15:8]};
  assign chk = ~sum[7:0];

  always_comb begin
    frame_byte = chk;
    case (idx_q)
      4'd0:    frame_byte = 8'h55;
      4'd1:    frame_byte = 8'h55;
      4'd2:    frame_byte = id_q;
      4'd3:    frame_byte = 8'h07;
      4'd4:    frame_byte = cmd_q;
      4'd5:    frame_byte = pos_q[7:0];
      4'd6:    frame_byte = pos_q[15:8];
      4'd7:    frame_byte = time_q[7:0];
      4'd8:    frame_byte = time_q[15:8];
      default: frame_byte = chk;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      idx_q   <= 4'd0;
      gap_q   <= '0;
      id_q    <= 8'h00;
      cmd_q   <= 8'h00;
      pos_q   <= 16'h0000;
      time_q  <= 16'h0000;
      data_q  <= 8'h00;
      send_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef TX_TIMEOUT_EN
      wd_q    <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      send_q <= 1'b0;
      done_q <= 1'b0;
`ifdef TX_TIMEOUT_EN
      err_q  <= 1'b0;
`endif
      case (state_q)
        S_IDLE: begin
          if (frame_start) begin
            id_q    <= servo_id;
            cmd_q   <= cmd;
            pos_q   <= pos;
            time_q  <= move_time;
            idx_q   <= 4'd0;
            busy_q  <= 1'b1;
            state_q <= S_SEND;
          end
        end
        S_SEND: begin
          data_q  <= frame_byte;
          send_q  <= 1'b1;
`ifdef TX_TIMEOUT_EN
          wd_q    <= '0;
`endif
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (tx_done) begin
            if (idx_q == 4'd9) begin
              state_q <= S_DONE;
            end else begin
              idx_q <= idx_q + 4'd1;
              gap_q <= '0;
              if (GAP_CYCLES == 0) state_q <= S_SEND;
              else                 state_q <= S_GAP;
            end
          end
`ifdef TX_TIMEOUT_EN
          else if (wd_q == WDW'(TIMEOUT_CYCLES - 1)) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
`endif
        end
        S_GAP: begin
          if (gap_q == GW'(GAP_CYCLES - 1)) begin
            gap_q   <= '0;
            state_q <= S_SEND;
          end else begin
            gap_q <= gap_q + 1'b1;
          end
        end
        S_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign data_byte  = data_q;
  assign send_en    = send_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

`ifdef TX_TIMEOUT_EN
  assign frame_err = err_q;
`else
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be positive");
  end
  assign frame_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_servo_frame_tx.sv
// Directed bench for uart_servo_frame_tx with a byte-transmitter model.
// Build with TX_TIMEOUT_EN to also exercise the watchdog (timeout 100).
module tb_uart_servo_frame_tx;

  localparam int GAP    = 16;
  localparam int TX_LAT = 3;
`ifdef TX_TIMEOUT_EN
  localparam int TMO = 100;
`else
  localparam int TMO = 1000000;
`endif

  logic        clk;
  logic        reset_n;
  logic        frame_start;
  logic        frame_start0;
  logic [7:0]  servo_id;
  logic [7:0]  cmd;
  logic [15:0] pos;
  logic [15:0] move_time;
  logic        tx_done;
  logic        tx_done0;
  logic [7:0]  data_byte, data_byte0;
  logic        send_en, send_en0;
  logic        busy, busy0;
  logic        frame_done, frame_done0;
  logic        frame_err, frame_err0;

  uart_servo_frame_tx #(
    .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)
  ) u_dut (
    .clk(clk), .reset_n(reset_n),
    .frame_start(frame_start), .servo_id(servo_id),
    .cmd(cmd), .pos(pos), .move_time(move_time),
    .tx_done(tx_done), .data_byte(data_byte),
    .send_en(send_en), .busy(busy),
    .frame_done(frame_done), .frame_err(frame_err)
  );

  uart_servo_frame_tx #(
    .GAP_CYCLES(0), .TIMEOUT_CYCLES(TMO)
  ) u_dut0 (
    .clk(clk), .reset_n(reset_n),
    .frame_start(frame_start0), .servo_id(servo_id),
    .cmd(cmd), .pos(pos), .move_time(move_time),
    .tx_done(tx_done0), .data_byte(data_byte0),
    .send_en(send_en0), .busy(busy0),
    .frame_done(frame_done0), .frame_err(frame_err0)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_assert = 0;
  int n_fail = 0;

  logic [7:0] q[$];
  int  send_cnt = 0, fd_cnt = 0, fe_cnt = 0, fe_total = 0;
  int  send_cyc = 0, fe_cyc = 0, txd_cyc = 0;
  bit  have_txd = 0;
  bit  tx_block = 0;

  logic [7:0] exp_a [10] = '{8'h55, 8'h55, 8'h01, 8'h07, 8'h01,
                             8'hF4, 8'h01, 8'hE8, 8'h03, 8'h16};
  // FE+07+01+FF*4 = 0x502 -> ~0x02 = 0xFD
  logic [7:0] exp_b [10] = '{8'h55, 8'h55, 8'hFE, 8'h07, 8'h01,
                             8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFD};

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Observe outputs on the falling edge
  initial forever begin
    @(negedge clk);
    if (send_en === 1'b1) begin
      if (have_txd) begin
        chk("gap_len", cyc - txd_cyc, GAP + 2);
        have_txd = 0;
      end
      q.push_back(data_byte);
      send_cnt++;
      send_cyc = cyc;
    end
    if (frame_done === 1'b1) begin
      fd_cnt++;
      have_txd = 0;
    end
    if (frame_err === 1'b1) begin
      fe_cnt++;
      fe_total++;
      fe_cyc = cyc;
    end
  end

  // Byte transmitter: tx_done TX_LAT cycles after each send_en
  initial begin
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (send_en === 1'b1 && !tx_block) begin
        repeat (TX_LAT) @(negedge clk);
        tx_done = 1'b1;
        txd_cyc = cyc;
        have_txd = 1;
        @(negedge clk);
        tx_done = 1'b0;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear();
    q.delete();
    send_cnt = 0;
    fd_cnt = 0;
    fe_cnt = 0;
  endtask

  task automatic wait_sends(input int n, input string tag);
    for (int i = 0; i < 1000 && send_cnt < n; i++) step();
    chk(tag, 32'(send_cnt >= n), 1);
  endtask

  task automatic wait_fd(input string tag);
    for (int i = 0; i < 1000 && fd_cnt < 1; i++) step();
    chk(tag, 32'(fd_cnt >= 1), 1);
  endtask

  task automatic set_in(input logic [7:0] id, input logic [15:0] p,
                        input logic [15:0] t);
    servo_id = id;
    cmd = 8'h01;
    pos = p;
    move_time = t;
  endtask

  task automatic check_bytes(input string tag, input logic [7:0] e [10]);
    logic [7:0] obs;
    chk({tag, "_cnt"}, q.size(), 10);
    for (int i = 0; i < 10; i++) begin
      obs = (i < q.size()) ? q[i] : 8'hxx;
      chk($sformatf("%s_b%0d", tag, i), obs, e[i]);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_data"}, data_byte, 8'h00);
    chk({tag, "_send"}, send_en, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_fdone"}, frame_done, 1'b0);
    chk({tag, "_ferr"}, frame_err, 1'b0);
  endtask

  initial begin
    int c0;
    reset_n = 1'b0;
    frame_start = 1'b0;
    frame_start0 = 1'b0;
    tx_done0 = 1'b0;
    set_in(8'h00, 16'h0000, 16'h0000);
    repeat (3) step();
    check_reset("rst");
    reset_n = 1'b1;
    step();

    // Frame A, with latency probe and ignored mid-frame request
    clear();
    set_in(8'h01, 16'd500, 16'd1000);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    chk("acc_busy", busy, 1'b1);
    chk("lat_early", send_en, 1'b0);
    step();
    chk("lat_send", send_en, 1'b1);
    chk("lat_byte", data_byte, 8'h55);
    pos = 16'hFFFF;
    wait_sends(3, "a_to3");
    servo_id = 8'h02;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    for (int i = 0; i < 1000 && !(send_cnt == 10 && tx_done === 1'b1); i++)
      step();
    chk("a_last_txd", tx_done, 1'b1);
    step();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    chk("a_fdone", frame_done, 1'b1);
    chk("a_busy_off", busy, 1'b0);
    step();
    chk("a_fdone_1cyc", frame_done, 1'b0);
    repeat (5) step();
    chk("done_start_ign", busy, 1'b0);
    chk("a_sends", send_cnt, 10);
    chk("a_fd_cnt", fd_cnt, 1);
    check_bytes("a", exp_a);

    // Frame B: all-ones payload, then start in the frame_done cycle
    clear();
    set_in(8'hFE, 16'hFFFF, 16'hFFFF);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    wait_fd("b_fd");
    chk("b_fd_now", frame_done, 1'b1);
    check_bytes("b", exp_b);
    clear();
    set_in(8'h01, 16'd500, 16'd1000);
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    chk("c_acc_busy", busy, 1'b1);
    step();
    chk("c_send", send_en, 1'b1);

    // Frame C: reset while waiting on byte 4, stray tx_done follows
    wait_sends(4, "c_to4");
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check_reset("midrst");
    repeat (20) step();
    chk("rst_no_send", send_cnt, 4);
    chk("rst_busy", busy, 1'b0);
    have_txd = 0;

    // Frame D: clean restart
    clear();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    wait_fd("d_fd");
    check_bytes("d", exp_a);
    step();
    chk("d_busy", busy, 1'b0);

    // Zero-gap instance
    frame_start0 = 1'b1;
    step();
    frame_start0 = 1'b0;
    step();
    chk("g0_send", send_en0, 1'b1);
    chk("g0_byte0", data_byte0, 8'h55);
    repeat (2) step();
    tx_done0 = 1'b1;
    c0 = cyc;
    step();
    tx_done0 = 1'b0;
    chk("g0_early", send_en0, 1'b0);
    step();
    chk("g0_lat", send_en0, 1'b1);
    chk("g0_dist", cyc - c0, 2);
    chk("g0_byte1", data_byte0, 8'h55);

`ifdef TX_TIMEOUT_EN
    clear();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    wait_sends(3, "t_to3");
    tx_block = 1;
    wait_sends(4, "t_to4");
    c0 = send_cyc;
    for (int i = 0; i < 300 && fe_cnt < 1; i++) step();
    chk("t_err_seen", fe_cnt, 1);
    chk("t_err_dly", fe_cyc - c0, TMO);
    chk("t_busy", busy, 1'b0);
    step();
    chk("t_err_1cyc", frame_err, 1'b0);
    chk("t_no_fd", fd_cnt, 0);
    chk("t_sends", send_cnt, 4);
    tx_block = 0;
`else
    chk("no_ferr", fe_total, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "bench timeout");
  end

endmodule
